bus2c02: RTL

- PPU-side counterpart of bus6502. Serves 2C02 pattern-table reads (ppu_addr[13]==0) from the CHR image already loaded into SDRAM.
- Watches the asynchronous PPU bus and issues single-byte SDRAM reads through the shared in_valid/busy/out_valid handshake.
- Holds the returned byte on ppu_data_out_run for the top-level tristate driver.
- Active only after init_sdram_data (read_flash_over) goes high.

---
 rtl/mojo_pkg.sv | 34 +++
 rtl/ppu_bus_sync.sv | 53 +++++
 rtl/bus2c02.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mojo_pkg.sv
// mojo_pkg: constants shared by the bus bridges (bus6502 / bus2c02).
//   SDRAM_ADDR_W     SDRAM byte-address width
//   PRG_BASE         SDRAM byte address of PRG byte 0
//   CHR_BASE         SDRAM byte address of CHR byte 0 (after 32 KiB PRG)
//   IDLE/ISSUE/WAIT  request FSM state encoding, wrapped by state_t
//   chr_map()        PPU pattern-table offset -> SDRAM byte address
package mojo_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int PPU_ADDR_W   = 14;
  localparam int CHR_OFS_W    = 13;

  localparam logic [SDRAM_ADDR_W-1:0] PRG_BASE = 23'h000000;
  localparam logic [SDRAM_ADDR_W-1:0] CHR_BASE = 23'h008000;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_WAIT  = WAIT
  } state_t;

  // Plain 23-bit add; the CHR image is assumed to fit below the top of SDRAM.
  function automatic logic [SDRAM_ADDR_W-1:0] chr_map(
    input logic [SDRAM_ADDR_W-1:0] base,
    input logic [CHR_OFS_W-1:0]    ofs
  );
    return base + {{(SDRAM_ADDR_W-CHR_OFS_W){1'b0}}, ofs};
  endfunction

endpackage

// File: rtl/ppu_bus_sync.sv
// ppu_bus_sync: brings an asynchronous read strobe and its address into the
// clk domain and flags the strobe's falling edge.
//   clk, rst    fabric clock, synchronous active-high reset
//   rd_n        raw read strobe, active low (asynchronous)
//   addr        raw address bus (asynchronous)
//   addr_sync   address after SYNC_STAGES flops, aligned with the strobe
//   rd_fall     one-cycle pulse when the synchronised strobe goes 1 -> 0
// Strobe and address use the same number of flops, so the address seen
// together with rd_fall is the one that was on the bus when rd_n fell.
module ppu_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_sync,
  output logic              rd_fall
);

  logic              rd_n_p [SYNC_STAGES];
  logic [ADDR_W-1:0] addr_p [SYNC_STAGES];
  logic              rd_n_prev;

  // Synchroniser chain; the strobe idles high so reset loads 1s.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rd_n_p[i] <= 1'b1;
      end
      rd_n_prev <= 1'b1;
    end else begin
      rd_n_p[0] <= rd_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rd_n_p[i] <= rd_n_p[i-1];
      end
      rd_n_prev <= rd_n_p[SYNC_STAGES-1];
    end
  end

  // Address is data: it only has to be stable when rd_fall is sampled.
  always_ff @(posedge clk) begin
    addr_p[0] <= addr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      addr_p[i] <= addr_p[i-1];
    end
  end

  assign addr_sync = addr_p[SYNC_STAGES-1];
  assign rd_fall   = rd_n_prev & ~rd_n_p[SYNC_STAGES-1];

endmodule

// File: rtl/bus2c02.sv
// bus2c02: PPU-side SDRAM bridge. Serves 2C02 pattern-table reads
// (ppu_addr[13]==0) from the CHR image held in SDRAM.
//   clk, rst          100 MHz fabric clock, synchronous active-high reset
//   ppu_addr          raw PPU address bus (asynchronous)
//   ppu_rd_n          raw PPU read strobe, active low (asynchronous)
//   ram_addr          SDRAM byte address, valid while in_valid is high
//   in_valid          one-cycle SDRAM read request
//   busy              SDRAM controller busy; requests wait while high
//   data_out          SDRAM read data (low byte)
//   out_valid         data_out valid, one cycle
//   ppu_data_out_run  byte presented to the PPU tristate driver
//   req_pending       a PPU read is waiting on SDRAM (for the arbiter)
//   init_sdram_data   CHR image loaded; new reads are ignored while low
// A one-entry cache holds the last fetched byte so that repeated reads of the
// same address cost nothing; a one-deep pending slot keeps the newest read
// that arrives while a fetch is still in flight.
module bus2c02 #(
  parameter logic [mojo_pkg::SDRAM_ADDR_W-1:0] CHR_BASE    = mojo_pkg::CHR_BASE,
  parameter int                                SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] ppu_addr,
  input  logic        ppu_rd_n,
  output logic [22:0] ram_addr,
  output logic        in_valid,
  input  logic        busy,
  input  logic [7:0]  data_out,
  input  logic        out_valid,
  output logic [7:0]  ppu_data_out_run,
  output logic        req_pending,
  input  logic        init_sdram_data
);

  import mojo_pkg::*;

  logic [PPU_ADDR_W-1:0] addr_sync;
  logic                  rd_fall;
  logic                  rd_req;
  logic [CHR_OFS_W-1:0]  rd_ofs;

  state_t                  state, state_n;
  logic [CHR_OFS_W-1:0]    cur_addr, cur_addr_n;
  logic [CHR_OFS_W-1:0]    pend_addr, pend_addr_n;
  logic                    pend_valid, pend_valid_n;
  logic [CHR_OFS_W-1:0]    cache_addr, cache_addr_n;
  logic                    cache_valid, cache_valid_n;
  logic [SDRAM_ADDR_W-1:0] ram_addr_n;
  logic                    in_valid_n;
  logic [7:0]              data_n;
  logic                    req_pending_n;
  logic [CHR_OFS_W-1:0]    nxt_addr;
  logic                    nxt_valid;

  ppu_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .ADDR_W     (PPU_ADDR_W)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rd_n     (ppu_rd_n),
    .addr     (ppu_addr),
    .addr_sync(addr_sync),
    .rd_fall  (rd_fall)
  );

  // Only pattern-table reads count, and only once the CHR image is loaded.
  assign rd_req = rd_fall & ~addr_sync[13] & init_sdram_data;
  assign rd_ofs = addr_sync[CHR_OFS_W-1:0];

  always_comb begin
    state_n       = state;
    cur_addr_n    = cur_addr;
    pend_addr_n   = pend_addr;
    pend_valid_n  = pend_valid;
    cache_addr_n  = cache_addr;
    cache_valid_n = cache_valid;
    ram_addr_n    = ram_addr;
    in_valid_n    = 1'b0;
    data_n        = ppu_data_out_run;
    req_pending_n = req_pending;
    nxt_addr      = pend_addr;
    nxt_valid     = pend_valid;

    case (state)
      ST_IDLE: begin
        // A hit needs no action: ppu_data_out_run already holds the byte.
        if (rd_req && !(cache_valid && rd_ofs == cache_addr)) begin
          cur_addr_n    = rd_ofs;
          req_pending_n = 1'b1;
          state_n       = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (rd_req) begin
          pend_addr_n  = rd_ofs;
          pend_valid_n = 1'b1;
        end
        if (!busy) begin
          in_valid_n = 1'b1;
          ram_addr_n = chr_map(CHR_BASE, cur_addr);
          state_n    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (out_valid) begin
          data_n        = data_out;
          cache_addr_n  = cur_addr;
          cache_valid_n = 1'b1;
          req_pending_n = 1'b0;
          pend_valid_n  = 1'b0;
          // A read arriving in this very cycle is newer than the slot.
          if (rd_req) begin
            nxt_addr  = rd_ofs;
            nxt_valid = 1'b1;
          end
          // Follow-up is checked against the just-committed cache entry.
          if (nxt_valid && init_sdram_data && nxt_addr != cur_addr) begin
            cur_addr_n    = nxt_addr;
            req_pending_n = 1'b1;
            state_n       = ST_ISSUE;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (rd_req) begin
          pend_addr_n  = rd_ofs;
          pend_valid_n = 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Losing the CHR image invalidates everything remembered; an in-flight
    // fetch still completes so the SDRAM handshake is never abandoned.
    if (!init_sdram_data) begin
      cache_valid_n = 1'b0;
      pend_valid_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      pend_valid       <= 1'b0;
      cache_valid      <= 1'b0;
      ram_addr         <= '0;
      in_valid         <= 1'b0;
      ppu_data_out_run <= 8'h00;
      req_pending      <= 1'b0;
    end else begin
      state            <= state_n;
      pend_valid       <= pend_valid_n;
      cache_valid      <= cache_valid_n;
      ram_addr         <= ram_addr_n;
      in_valid         <= in_valid_n;
      ppu_data_out_run <= data_n;
      req_pending      <= req_pending_n;
    end
  end

  // Address holders are qualified by the valid flags above.
  always_ff @(posedge clk) begin
    cur_addr   <= cur_addr_n;
    pend_addr  <= pend_addr_n;
    cache_addr <= cache_addr_n;
  end

endmodule
